// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, baud divider helpers, frame width.
// Used by both the receive and transmit ends of the 16-bit link.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int half_div(input int clk_freq, input int baud);
        return baud_div(clk_freq, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// One 8N1 byte receiver: input synchronizer, mid-bit sampling FSM and baud counter.
// Emits single-cycle byte_done / byte_err strobes in the cycle of the stop-bit sample.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] byte_data,
    output logic                 byte_done,
    output logic                 byte_err,
    output logic                 start_det,
    output logic                 busy
);

    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
    localparam int HALF_DIV = half_div(CLK_FREQ, BAUD);
    localparam int CNT_W    = $clog2(BAUD_DIV + 1);
    localparam int BIT_W    = $clog2(DATA_BITS);

    logic                 rxd_meta, rxd_sync, rxd_prev;
    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;

    // Synchronizer resets to the idle level so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    assign start_det = (state_q == IDLE) && rxd_prev && !rxd_sync;
    assign busy      = (state_q != IDLE);
    assign byte_data = shift_q;

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        byte_err  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_det) begin
                    state_d = START;
                    bit_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_W'(HALF_DIV - 1)) begin
                    cnt_d   = '0;
                    state_d = rxd_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_W'(BAUD_DIV - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rxd_sync, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_W'(DATA_BITS - 1)) state_d = STOP;
                end
            end
            STOP: begin
                // Leave mid-stop-bit so a back-to-back start edge is not missed.
                if (cnt_q == CNT_W'(BAUD_DIV - 1)) begin
                    cnt_d     = '0;
                    state_d   = IDLE;
                    byte_done = rxd_sync;
                    byte_err  = !rxd_sync;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values together.
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/uart_rx_16.sv
// 16-bit UART receiver: pairs two 8N1 bytes (high first) into data_16 with a valid pulse.
// Define UART_RX_TIMEOUT_EN to drop a lone first byte after TIMEOUT_BITS idle bit times.
module uart_rx_16
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   uart_rxd,
    output logic [2*DATA_BITS-1:0] data_16,
    output logic                   data_valid,
    output logic                   frame_err,
    output logic                   rx_timeout,
    output logic                   rx_busy
);

    logic [DATA_BITS-1:0] byte_data, high_byte;
    logic                 byte_done, byte_err, start_det;
    logic                 byte_idx;
    logic                 timeout_hit;

    uart_rx_byte #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_byte (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .rxd       (uart_rxd),
        .byte_data (byte_data),
        .byte_done (byte_done),
        .byte_err  (byte_err),
        .start_det (start_det),
        .busy      (rx_busy)
    );

    // A framing error discards any half-built word so alignment restarts on the next byte.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            byte_idx   <= 1'b0;
            high_byte  <= '0;
            data_16    <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (byte_err) begin
                frame_err <= 1'b1;
                byte_idx  <= 1'b0;
            end else if (byte_done) begin
                if (!byte_idx) begin
                    high_byte <= byte_data;
                    byte_idx  <= 1'b1;
                end else begin
                    data_16    <= {high_byte, byte_data};
                    data_valid <= 1'b1;
                    byte_idx   <= 1'b0;
                end
            end else if (timeout_hit) begin
                byte_idx <= 1'b0;
            end
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int BAUD_DIV  = baud_div(CLK_FREQ, BAUD);
    localparam int TMO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
    localparam int TMO_W     = $clog2(TMO_LIMIT + 1);

    logic [TMO_W-1:0] idle_cnt;
    logic             idle_run;

    assign idle_run    = byte_idx && !rx_busy && !start_det;
    assign timeout_hit = idle_run && (idle_cnt == TMO_W'(TMO_LIMIT - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idle_cnt   <= '0;
            rx_timeout <= 1'b0;
        end else begin
            rx_timeout <= timeout_hit;
            if (!idle_run || timeout_hit) idle_cnt <= '0;
            else                          idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    logic unused_tmo;

    assign unused_tmo  = start_det ^ (TIMEOUT_BITS == 0);
    assign timeout_hit = 1'b0;
    assign rx_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_16.sv
// Self-checking bench for uart_rx_16: vector table, directed corner cases, randomized word stream.
// Expectations follow the UART_RX_TIMEOUT_EN setting of the build.
module tb_uart_rx_16;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 3_125_000;
    localparam int BD       = CLK_FREQ / BAUD;
    localparam int HALF     = BD / 2;
    localparam int TMO_BITS = 20;
`ifdef UART_RX_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        uart_rxd  = 1'b1;
    logic [15:0] data_16;
    logic        data_valid, frame_err, rx_timeout, rx_busy;

    uart_rx_16 #(
        .CLK_FREQ     (CLK_FREQ),
        .BAUD         (BAUD),
        .TIMEOUT_BITS (TMO_BITS)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .uart_rxd   (uart_rxd),
        .data_16    (data_16),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .rx_timeout (rx_timeout),
        .rx_busy    (rx_busy)
    );

    always #10 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_cnt = 0, err_cnt = 0, tmo_cnt = 0;
    int last_valid_cyc = 0, last_tmo_cyc = 0;
    int start_cyc = 0;
    logic [15:0] got_q[$];

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (data_valid) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
            got_q.push_back(data_16);
        end
        if (frame_err) err_cnt <= err_cnt + 1;
        if (rx_timeout) begin
            tmo_cnt      <= tmo_cnt + 1;
            last_tmo_cyc <= cyc;
        end
    end

    initial begin
        #(80_000 * 20);
        $display("FAIL watchdog: run still active at cycle %0d, required to end earlier", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        checks++;
        if (val < lo || val > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, val, lo, hi);
        end
    endtask

    task automatic wait_bits(input int n);
        uart_rxd = 1'b1;
        repeat (n * BD) @(negedge sys_clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rxd  = 1'b0;
        start_cyc = cyc;
        repeat (BD) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (BD) @(negedge sys_clk);
        end
        uart_rxd = stop_bit;
        repeat (BD) @(negedge sys_clk);
        uart_rxd = 1'b1;
    endtask

    typedef struct {
        int          pre_bits;
        logic [7:0]  hi;
        logic [7:0]  lo;
        int          gap_bits;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int v0, e0, t0, tstart;
        logic [15:0] prev;
        logic [7:0]  b2;
        logic [7:0]  pend;
        logic        pend_valid;
        int          exp_err, exp_tmo;
        logic [15:0] exp_q[$];

        vecs[0] = '{0,  8'h12, 8'h34, 0, 16'h1234};
        vecs[1] = '{60, 8'h43, 8'h21, 0, 16'h4321};
        vecs[2] = '{3,  8'hA5, 8'h5A, 3, 16'hA55A};
        vecs[3] = '{1,  8'hFF, 8'h00, 0, 16'hFF00};
        vecs[4] = '{2,  8'h00, 8'hFF, 5, 16'h00FF};

        // Reset state
        repeat (3) @(negedge sys_clk);
        check("reset data_16", data_16, 16'h0);
        check("reset data_valid", data_valid, 1'b0);
        check("reset frame_err", frame_err, 1'b0);
        check("reset rx_timeout", rx_timeout, 1'b0);
        check("reset rx_busy", rx_busy, 1'b0);
        sys_rst_n = 1'b1;
        wait_bits(2);

        // Word table
        prev = 16'h0;
        for (int i = 0; i < 5; i++) begin
            wait_bits(vecs[i].pre_bits);
            v0 = valid_cnt;
            e0 = err_cnt;
            send_byte(vecs[i].hi, 1'b1);
            tstart = start_cyc;
            check($sformatf("vec%0d hold", i), data_16, prev);
            wait_bits(vecs[i].gap_bits);
            send_byte(vecs[i].lo, 1'b1);
            wait_bits(2);
            check($sformatf("vec%0d valid count", i), valid_cnt - v0, 1);
            check($sformatf("vec%0d frame_err count", i), err_cnt - e0, 0);
            check($sformatf("vec%0d data_16", i), data_16, vecs[i].exp_data);
            if (i == 0)
                check_range("latency", last_valid_cyc - tstart, (39 * BD) / 2 + 1, (39 * BD) / 2 + 5);
            prev = vecs[i].exp_data;
        end

        // False start from a 100 ns glitch
        v0 = valid_cnt;
        e0 = err_cnt;
        begin
            logic seen_busy;
            seen_busy = 1'b0;
            uart_rxd  = 1'b0;
            for (int k = 1; k <= HALF + 3; k++) begin
                @(negedge sys_clk);
                if (k == 5) uart_rxd = 1'b1;
                if (rx_busy) seen_busy = 1'b1;
            end
            check("glitch busy seen", seen_busy, 1'b1);
            check("glitch busy cleared", rx_busy, 1'b0);
        end
        wait_bits(3);
        check("glitch no valid", valid_cnt - v0, 0);
        check("glitch no frame_err", err_cnt - e0, 0);

        // Framing error then realignment
        v0 = valid_cnt;
        e0 = err_cnt;
        send_byte(8'h12, 1'b0);
        wait_bits(2);
        check("ferr data held", data_16, 16'h00FF);
        send_byte(8'h43, 1'b1);
        send_byte(8'h21, 1'b1);
        wait_bits(2);
        check("ferr count", err_cnt - e0, 1);
        check("ferr valid count", valid_cnt - v0, 1);
        check("ferr realign data", data_16, 16'h4321);

        // Break: line held low
        v0 = valid_cnt;
        e0 = err_cnt;
        uart_rxd = 1'b0;
        repeat (30 * BD) @(negedge sys_clk);
        wait_bits(3);
        check("break frame_err once", err_cnt - e0, 1);
        check("break no valid", valid_cnt - v0, 0);

        // Lone first byte followed by a long idle
        v0 = valid_cnt;
        t0 = tmo_cnt;
        send_byte(8'h55, 1'b1);
        tstart = start_cyc;
        wait_bits(25);
        send_byte(8'h43, 1'b1);
        send_byte(8'h21, 1'b1);
        wait_bits(2);
        check("timeout valid count", valid_cnt - v0, 1);
        if (TMO_EN) begin
            check("timeout pulses", tmo_cnt - t0, 1);
            check_range("timeout timing", last_tmo_cyc - tstart,
                        3 + HALF + 9 * BD + TMO_BITS * BD - 2, 3 + HALF + 9 * BD + TMO_BITS * BD + 2);
            check("timeout data_16", data_16, 16'h4321);
        end else begin
            check("no-timeout pulses", tmo_cnt - t0, 0);
            check("no-timeout data_16", data_16, 16'h5543);
        end

        // Reset during bit 4 of the second byte
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        wait_bits(2);
        send_byte(8'h11, 1'b1);
        b2 = 8'h22;
        uart_rxd = 1'b0;
        repeat (BD) @(negedge sys_clk);
        for (int i = 0; i < 4; i++) begin
            uart_rxd = b2[i];
            repeat (BD) @(negedge sys_clk);
        end
        uart_rxd = b2[4];
        repeat (HALF) @(negedge sys_clk);
        v0 = valid_cnt;
        e0 = err_cnt;
        sys_rst_n = 1'b0;
        repeat (4) @(negedge sys_clk);
        check("midreset data_16", data_16, 16'h0);
        check("midreset rx_busy", rx_busy, 1'b0);
        uart_rxd = 1'b1;
        repeat (BD) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        wait_bits(3);
        check("midreset no valid", valid_cnt - v0, 0);
        check("midreset no frame_err", err_cnt - e0, 0);
        v0 = valid_cnt;
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        wait_bits(2);
        check("post-reset valid count", valid_cnt - v0, 1);
        check("post-reset data_16", data_16, 16'hABCD);

        // Randomized byte stream against a word-pairing model
        got_q.delete();
        e0 = err_cnt;
        t0 = tmo_cnt;
        exp_err = 0;
        exp_tmo = 0;
        pend = 8'h00;
        pend_valid = 1'b0;
        for (int k = 0; k < 24; k++) begin
            logic [7:0] b;
            logic       ok;
            int         gap;
            b   = 8'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 7) != 0);
            gap = ($urandom_range(0, 5) == 0) ? 25 : int'($urandom_range(1, 5));
            wait_bits(gap);
            if (TMO_EN && gap >= TMO_BITS && pend_valid) begin
                pend_valid = 1'b0;
                exp_tmo++;
            end
            send_byte(b, ok);
            if (!ok) begin
                exp_err++;
                pend_valid = 1'b0;
            end else if (pend_valid) begin
                exp_q.push_back({pend, b});
                pend_valid = 1'b0;
            end else begin
                pend = b;
                pend_valid = 1'b1;
            end
        end
        wait_bits(3);
        check("random word count", got_q.size(), exp_q.size());
        check("random frame_err count", err_cnt - e0, exp_err);
        check("random timeout count", tmo_cnt - t0, exp_tmo);
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size())
                check($sformatf("random word %0d", i), got_q[i], exp_q[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
